// File: rtl/rr_counter_scheduler_if.sv
// Request/grant/ticket bundle between requesters and the shared sequence counter.
// The master modport is the requester side; the slave modport is the scheduler.
interface rr_counter_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 11
);
  logic [NREQ-1:0]  req;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] ticket;
  logic             ticket_vld;
  logic [WIDTH-1:0] c;

  modport master (
    output req, load, load_val,
    input  gnt, ticket, ticket_vld, c
  );

  modport slave (
    input  req, load, load_val,
    output gnt, ticket, ticket_vld, c
  );
endinterface

// File: rtl/rr_counter_scheduler.sv
// Round-robin access to one modular sequence counter (1..LIMIT, wraps to 1).
// Each grant advances the counter and hands the new value back as a ticket.
module rr_counter_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 11,
  parameter int LIMIT = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_counter_scheduler_if.slave bus
);
  localparam int               PTR_W    = $clog2(NREQ);
  localparam logic [WIDTH-1:0] LIMIT_W  = WIDTH'(LIMIT);
  localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NREQ - 1);

  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] ticket_q, ticket_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             ticket_vld_q, ticket_vld_d;
  logic [PTR_W-1:0] last_q, last_d;

  logic             found;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] cand;

  // Scan starts just past the last winner, so a re-asserted request waits its turn.
  always_comb begin
    c_d      = c_q;
    ticket_d = ticket_q;
    gnt_d    = '0;
    last_d   = last_q;
    found    = 1'b0;
    win      = last_q;
    cand     = '0;

    for (int k = 1; k <= NREQ; k++) begin
      cand = PTR_W'((int'(last_q) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    // A load takes the cycle; pending requests simply compete again next cycle.
    if (bus.load) begin
      c_d = (bus.load_val > LIMIT_W) ? LIMIT_W : bus.load_val;
    end else if (found) begin
      c_d        = (c_q >= LIMIT_W) ? WIDTH'(1) : c_q + WIDTH'(1);
      ticket_d   = c_d;
      gnt_d[win] = 1'b1;
      last_d     = win;
    end

    ticket_vld_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q          <= '0;
      ticket_q     <= '0;
      gnt_q        <= '0;
      ticket_vld_q <= 1'b0;
      last_q       <= LAST_RST;
    end else begin
      c_q          <= c_d;
      ticket_q     <= ticket_d;
      gnt_q        <= gnt_d;
      ticket_vld_q <= ticket_vld_d;
      last_q       <= last_d;
    end
  end

  assign bus.c          = c_q;
  assign bus.ticket     = ticket_q;
  assign bus.gnt        = gnt_q;
  assign bus.ticket_vld = ticket_vld_q;
endmodule
